frame_arbiter: RTL and testbench

FRAME_ARBITER -- requirements
Module: frame_arbiter

---
 rtl/frame_arbiter.sv | 210 +++++++++++++++++++++
 tb/tb_frame_arbiter.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/frame_arbiter.sv
// Round-robin arbiter that turns one granted requester's transaction into a
// serial command frame, waits for the response, then reports done/err.
// Optional macro ARB_TIMEOUT_EN adds a response-wait timeout.

package frame_arbiter_pkg;
  localparam int unsigned ADDR_WIDTH = 16;
  localparam int unsigned DATA_WIDTH = 8;

  typedef enum logic {
    CMD_READ  = 1'b0,
    CMD_WRITE = 1'b1
  } cmd_e;

  typedef struct packed {
    logic                  start;
    cmd_e                  cmd;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] data;
    logic                  stop;
  } serial_frame_t;
endpackage

module frame_arbiter
  import frame_arbiter_pkg::*;
#(
  parameter int unsigned NUM_REQ        = 2,
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic [NUM_REQ-1:0]            req_i,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] addr_i,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] wdata_i,
  input  logic [NUM_REQ-1:0]            we_i,
  output logic [NUM_REQ-1:0]            gnt_o,
  output logic [NUM_REQ-1:0]            done_o,
  output logic [NUM_REQ-1:0]            err_o,
  output logic                          frame_valid_o,
  output serial_frame_t                 frame_o,
  input  logic                          frame_ready_i,
  input  logic                          resp_valid_i,
  input  logic                          resp_err_i
);

  localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  // Reject out-of-range configurations at elaboration.
  if (NUM_REQ < 2 || NUM_REQ > 8) begin : g_bad_num_req
    $error("frame_arbiter: NUM_REQ must be 2..8");
  end
  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
    $error("frame_arbiter: TIMEOUT_CYCLES must be 1..255");
  end

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_SEND,
    ARB_WAIT,
    ARB_DONE
  } arb_state_e;

  arb_state_e           state_q, state_d;
  logic [IDX_W-1:0]     ptr_q, ptr_d;
  logic [IDX_W-1:0]     win_q, win_d;
  logic [NUM_REQ-1:0]   gnt_q, gnt_d;
  logic [NUM_REQ-1:0]   done_q, done_d;
  logic [NUM_REQ-1:0]   err_q, err_d;
  logic                 fvalid_q, fvalid_d;
  serial_frame_t        frame_q, frame_d;

  logic                  pick_found;
  logic [IDX_W-1:0]      pick_idx;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [DATA_WIDTH-1:0] sel_wdata;
  logic                  sel_we;

`ifdef ARB_TIMEOUT_EN
  localparam int unsigned CNT_W = 8;
  logic [CNT_W-1:0] cnt_q, cnt_d;
`endif

  // Round-robin search: first requester at or after the pointer, wrapping.
  always_comb begin
    int unsigned cand;
    cand       = 0;
    pick_found = 1'b0;
    pick_idx   = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      cand = int'(ptr_q) + i;
      if (cand >= NUM_REQ) cand = cand - NUM_REQ;
      if (!pick_found && req_i[IDX_W'(cand)]) begin
        pick_found = 1'b1;
        pick_idx   = IDX_W'(cand);
      end
    end
  end

  // Payload mux for the selected requester.
  always_comb begin
    sel_addr  = '0;
    sel_wdata = '0;
    sel_we    = 1'b0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (IDX_W'(i) == pick_idx) begin
        sel_addr  = addr_i[i*ADDR_WIDTH +: ADDR_WIDTH];
        sel_wdata = wdata_i[i*DATA_WIDTH +: DATA_WIDTH];
        sel_we    = we_i[i];
      end
    end
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    win_d    = win_q;
    gnt_d    = gnt_q;
    done_d   = '0;
    err_d    = '0;
    fvalid_d = fvalid_q;
    frame_d  = frame_q;
`ifdef ARB_TIMEOUT_EN
    cnt_d    = cnt_q;
`endif
    case (state_q)
      ARB_IDLE: begin
        if (pick_found) begin
          win_d         = pick_idx;
          gnt_d         = NUM_REQ'(1) << pick_idx;
          frame_d.start = 1'b1;
          frame_d.cmd   = sel_we ? CMD_WRITE : CMD_READ;
          frame_d.addr  = sel_addr;
          frame_d.data  = sel_we ? sel_wdata : '0;
          frame_d.stop  = 1'b1;
          fvalid_d      = 1'b1;
          state_d       = ARB_SEND;
        end
      end
      ARB_SEND: begin
        if (fvalid_q && frame_ready_i) begin
          fvalid_d = 1'b0;
          state_d  = ARB_WAIT;
`ifdef ARB_TIMEOUT_EN
          cnt_d    = '0;
`endif
        end
      end
      ARB_WAIT: begin
        if (resp_valid_i) begin
          done_d  = gnt_q;
          err_d   = resp_err_i ? gnt_q : '0;
          state_d = ARB_DONE;
        end
`ifdef ARB_TIMEOUT_EN
        else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          done_d  = gnt_q;
          err_d   = gnt_q;
          state_d = ARB_DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
`endif
      end
      ARB_DONE: begin
        gnt_d   = '0;
        ptr_d   = (win_q == IDX_W'(NUM_REQ - 1)) ? '0 : win_q + IDX_W'(1);
        state_d = ARB_IDLE;
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q  <= ARB_IDLE;
      ptr_q    <= '0;
      win_q    <= '0;
      gnt_q    <= '0;
      done_q   <= '0;
      err_q    <= '0;
      fvalid_q <= 1'b0;
      frame_q  <= '0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      win_q    <= win_d;
      gnt_q    <= gnt_d;
      done_q   <= done_d;
      err_q    <= err_d;
      fvalid_q <= fvalid_d;
      frame_q  <= frame_d;
    end
  end

`ifdef ARB_TIMEOUT_EN
  // Response-wait counter.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end
`endif

  assign gnt_o         = gnt_q;
  assign done_o        = done_q;
  assign err_o         = err_q;
  assign frame_valid_o = fvalid_q;
  assign frame_o       = frame_q;

endmodule

// File: tb/tb_frame_arbiter.sv
// Scoreboard bench for frame_arbiter: the driver predicts each transaction's
// frame and completion from round-robin rules and queues them; a negedge
// monitor pops and compares whenever the DUT presents a frame or done pulse.

module tb_frame_arbiter;
  import frame_arbiter_pkg::*;

  localparam int unsigned N  = 3;
  localparam int unsigned TO = 8;
  localparam int unsigned AW = ADDR_WIDTH;
  localparam int unsigned DW = DATA_WIDTH;

  logic            clk = 1'b0;
  logic            rst_ni;
  logic [N-1:0]    req;
  logic [N*AW-1:0] addr;
  logic [N*DW-1:0] wdata;
  logic [N-1:0]    we;
  logic [N-1:0]    gnt, done, err;
  logic            frame_valid;
  serial_frame_t   frame;
  logic            frame_ready, resp_valid, resp_err;

  always #5 clk = ~clk;

  frame_arbiter #(.NUM_REQ(N), .TIMEOUT_CYCLES(TO)) dut (
    .clk_i(clk), .rst_ni(rst_ni), .req_i(req), .addr_i(addr), .wdata_i(wdata),
    .we_i(we), .gnt_o(gnt), .done_o(done), .err_o(err),
    .frame_valid_o(frame_valid), .frame_o(frame), .frame_ready_i(frame_ready),
    .resp_valid_i(resp_valid), .resp_err_i(resp_err)
  );

  typedef struct {
    int unsigned   cyc;
    serial_frame_t frame;
    logic [N-1:0]  gnt;
  } exp_frame_t;

  typedef struct {
    int unsigned  cyc;
    logic [N-1:0] done;
    logic [N-1:0] err;
  } exp_done_t;

  exp_frame_t  fq[$];
  exp_done_t   dq[$];
  int unsigned cyc = 0;
  int          n_cmp = 0;
  int          n_fail = 0;

  // Reference model state: round-robin pointer and per-requester payloads.
  int          mptr = 0;
  logic [AW-1:0] m_addr [N];
  logic [DW-1:0] m_wdata[N];
  logic          m_we   [N];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @cyc %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic int rr_pick(input logic [N-1:0] r, input int p);
    for (int i = 0; i < int'(N); i++) begin
      int idx;
      idx = (p + i) % int'(N);
      if (r[idx]) return idx;
    end
    return -1;
  endfunction

  task automatic drive_payload();
    for (int i = 0; i < int'(N); i++) begin
      addr[i*AW +: AW]  = m_addr[i];
      wdata[i*DW +: DW] = m_wdata[i];
      we[i]             = m_we[i];
    end
  endtask

  task automatic new_payload();
    for (int i = 0; i < int'(N); i++) begin
      m_addr[i]  = AW'($urandom);
      m_wdata[i] = DW'($urandom);
      m_we[i]    = 1'($urandom);
    end
  endtask

  task automatic scramble();
    req   = N'($urandom);
    addr  = (N*AW)'({$urandom, $urandom});
    wdata = (N*DW)'($urandom);
    we    = N'($urandom);
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_gnt"},   64'(gnt), 64'd0);
    check({tag, "_done"},  64'(done), 64'd0);
    check({tag, "_err"},   64'(err), 64'd0);
    check({tag, "_valid"}, 64'(frame_valid), 64'd0);
    check({tag, "_frame"}, 64'(frame), 64'd0);
  endtask

  task automatic reset_dut();
    rst_ni = 1'b0; req = '0; frame_ready = 1'b0; resp_valid = 1'b0; resp_err = 1'b0;
    step();
    check_zero_outputs("reset");
    rst_ni = 1'b1;
    mptr   = 0;
  endtask

  // One transaction: k ready-stall cycles, response after d wait cycles.
  task automatic run_round(input logic [N-1:0] r, input bit hold, input int k,
                           input int d, input bit e, input bit abort);
    int            w, eff_d;
    bit            eff_e, responds;
    int unsigned   c0;
    serial_frame_t f;
    logic [N-1:0]  oh;
    w = rr_pick(r, mptr);
    oh = N'(1) << w;
    f.start = 1'b1;
    f.cmd   = m_we[w] ? CMD_WRITE : CMD_READ;
    f.addr  = m_addr[w];
    f.data  = m_we[w] ? m_wdata[w] : '0;
    f.stop  = 1'b1;
    eff_d = d; eff_e = e; responds = 1'b1;
`ifdef ARB_TIMEOUT_EN
    if (d >= int'(TO)) begin
      eff_d = int'(TO) - 1; eff_e = 1'b1; responds = 1'b0;
    end
`endif
    req = r; drive_payload();
    frame_ready = 1'b0; resp_valid = 1'b0; resp_err = 1'b0;
    c0 = cyc;
    fq.push_back('{c0 + 1 + k, f, oh});
    if (!abort) dq.push_back('{c0 + 3 + k + eff_d, oh, eff_e ? oh : '0});
    step();
    for (int j = 0; j < k; j++) begin
      if (!hold) scramble();
      frame_ready = 1'b0;
      resp_valid  = 1'($urandom);
      resp_err    = 1'($urandom);
      step();
    end
    if (!hold) scramble();
    frame_ready = 1'b1;
    resp_valid  = 1'($urandom);
    step();
    frame_ready = 1'b0; resp_valid = 1'b0;
    if (abort) begin
      for (int j = 0; j < 2; j++) step();
      rst_ni = 1'b0;
      step();
      check_zero_outputs("abort");
      rst_ni = 1'b1;
      mptr   = 0;
      return;
    end
    for (int j = 0; j < eff_d; j++) begin
      if (!hold) scramble();
      resp_valid = 1'b0;
      step();
    end
    resp_valid = responds;
    resp_err   = e;
    step();
    resp_valid = 1'($urandom);
    resp_err   = 1'($urandom);
    step();
    resp_valid = 1'b0;
    mptr = (w + 1) % int'(N);
  endtask

  // Monitor: compare every presented frame and done pulse with the scoreboard.
  always @(negedge clk) begin
    check("gnt_onehot0", 64'($onehot0(gnt)), 64'd1);
    if (fq.size() != 0 && (cyc == fq[0].cyc || (frame_valid && frame_ready))) begin
      check("accept_cycle", 64'(cyc), 64'(fq[0].cyc));
      check("accept_hs", 64'({frame_valid, frame_ready}), 64'd3);
      check("frame", 64'(frame), 64'(fq[0].frame));
      check("gnt_at_accept", 64'(gnt), 64'(fq[0].gnt));
      void'(fq.pop_front());
    end else if (frame_valid) begin
      if (fq.size() == 0) begin
        n_cmp++; n_fail++;
        $display("FAIL unexpected_frame @cyc %0d: got frame %h expected none", cyc, frame);
      end else begin
        check("frame_stall", 64'(frame), 64'(fq[0].frame));
        check("gnt_stall", 64'(gnt), 64'(fq[0].gnt));
      end
    end
    if (dq.size() != 0 && (cyc == dq[0].cyc || (|done))) begin
      check("done_cycle", 64'(cyc), 64'(dq[0].cyc));
      check("done", 64'(done), 64'(dq[0].done));
      check("err", 64'(err), 64'(dq[0].err));
      void'(dq.pop_front());
    end else if ((|done) || (|err)) begin
      n_cmp++; n_fail++;
      $display("FAIL unexpected_done @cyc %0d: got done %b err %b expected none", cyc, done, err);
    end
  end

  initial begin
    rst_ni = 1'b0; req = '0; addr = '0; wdata = '0; we = '0;
    frame_ready = 1'b0; resp_valid = 1'b0; resp_err = 1'b0;
    step();
    reset_dut();
    reset_dut();

    // Single write from requester 0, minimum latency.
    new_payload();
    m_addr[0] = 16'h0010; m_wdata[0] = 8'hA5; m_we[0] = 1'b1;
    run_round(3'b001, 1'b1, 0, 0, 1'b0, 1'b0);

    // Two requesters held: grants alternate 0,1,0,1 from a fresh pointer.
    reset_dut();
    new_payload();
    for (int t = 0; t < 4; t++) run_round(3'b011, 1'b1, 0, 0, 1'b0, 1'b0);

    // Ready held low five cycles, requests dropped after grant.
    new_payload();
    run_round(3'b100, 1'b0, 5, 1, 1'b0, 1'b0);

    // Response flagged bad.
    new_payload();
    run_round(3'b010, 1'b0, 0, 0, 1'b1, 1'b0);

    // Long response wait: times out with the macro, otherwise waits it out.
    new_payload();
    run_round(3'b001, 1'b1, 0, 20, 1'b0, 1'b0);

    // Reset mid-wait aborts without done, then grant restarts at index 0.
    new_payload();
    run_round(3'b110, 1'b1, 1, 10, 1'b0, 1'b1);
    new_payload();
    run_round(3'b111, 1'b1, 0, 0, 1'b0, 1'b0);

    // Randomized traffic with idle gaps and stray inputs.
    for (int t = 0; t < 40; t++) begin
      new_payload();
      run_round(N'($urandom_range(1, (1 << N) - 1)), 1'($urandom),
                int'($urandom_range(0, 4)), int'($urandom_range(0, 10)),
                1'($urandom), 1'b0);
      if ($urandom_range(0, 3) == 0) begin
        for (int g = 0; g < int'($urandom_range(1, 3)); g++) begin
          req = '0; frame_ready = 1'b1;
          resp_valid = 1'($urandom); resp_err = 1'($urandom);
          step();
        end
        frame_ready = 1'b0; resp_valid = 1'b0;
      end
    end

    req = '0;
    for (int j = 0; j < 5; j++) step();
    check("frames_left", 64'(fq.size()), 64'd0);
    check("dones_left", 64'(dq.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
